// File: rtl/seg_borrow_select_sub_pkg.sv
// Shared definitions for the segmented borrow-select subtractor.
// Holds the controller state type, default geometry, the segment-index
// width helper and the signed-overflow flag function.
package seg_borrow_select_sub_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SEG_W_DEF = 4;
    localparam int NSEG_DEF  = WIDTH_DEF / SEG_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter needs at least one bit even when there is a single segment.
    function automatic int seg_idx_w(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

    // Two's-complement overflow of a - b: operands of opposite sign and
    // the result sign differs from the minuend. Shared with the adder flags
    // by passing the inverted b sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/seg_borrow_select_sub_if.sv
// Operand/result handshake bundle for seg_borrow_select_sub.
// master: producer of operands and consumer of results (testbench / datapath).
// slave : the subtractor.
//   in_valid/in_ready, a, b, bin      operand side
//   out_valid/out_ready, diff, bout,
//   zero, ovf                         result side
interface seg_borrow_select_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );

endinterface

// File: rtl/seg_borrow_select_sub_csel.sv
// One borrow-select segment of the subtractor (combinational).
//   a_seg, b_seg : SEG_W-bit operand slices
//   bsel         : running borrow into this segment
//   d_seg        : SEG_W-bit difference slice
//   bout_seg     : borrow out of this segment
// The borrow-in=1 result (a + ~b) is formed first; the borrow-in=0 result
// is its +1 increment, so only one full adder chain is needed.
module seg_csel_sub #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             bsel,
    output logic [SEG_W-1:0] d_seg,
    output logic             bout_seg
);

    logic [SEG_W:0] d1;
    logic [SEG_W:0] d0;
    logic [SEG_W:0] sel;

    assign d1  = {1'b0, a_seg} + {1'b0, ~b_seg};
    assign d0  = d1 + (SEG_W+1)'(1);
    assign sel = bsel ? d1 : d0;

    // Carry out of the complement-add means no borrow.
    assign d_seg    = sel[SEG_W-1:0];
    assign bout_seg = ~sel[SEG_W];

endmodule

// File: rtl/seg_borrow_select_sub.sv
// Multi-cycle segmented subtractor: diff = a - b - bin, one SEG_W-bit
// segment per clock, lowest segment first.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of seg_borrow_select_sub_if (operands in,
//                diff/bout/zero/ovf out, valid/ready both sides)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one segment resolved per cycle
// DONE  | result held on out_valid until out_ready
module seg_borrow_select_sub
    import seg_borrow_select_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_borrow_select_sub_if.slave bus
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int IDX_W = seg_idx_w(NSEG);

    generate
        if (WIDTH % SEG_W != 0) begin : g_bad_geometry
            $error("seg_borrow_select_sub: WIDTH must be a multiple of SEG_W");
        end
    endgenerate

    state_t           state;
    logic [IDX_W-1:0] seg_idx;
    logic             borrow;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             out_valid_r;
    logic             bout_r;
    logic             zero_r;
    logic             ovf_r;

    logic [SEG_W-1:0] a_seg;
    logic [SEG_W-1:0] b_seg;
    logic [SEG_W-1:0] d_seg;
    logic             bout_seg;
    logic [WIDTH-1:0] diff_nxt;
    logic             last_seg;

    // Segment mux and write-back; diff_nxt is the word as it will stand
    // after this cycle, so the final flags see the completed result.
    always_comb begin
        a_seg    = '0;
        b_seg    = '0;
        diff_nxt = diff_r;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_idx == IDX_W'(k)) begin
                a_seg                       = a_r[k*SEG_W +: SEG_W];
                b_seg                       = b_r[k*SEG_W +: SEG_W];
                diff_nxt[k*SEG_W +: SEG_W] = d_seg;
            end
        end
    end

    assign last_seg = (seg_idx == IDX_W'(NSEG - 1));

    seg_csel_sub #(.SEG_W(SEG_W)) u_csel (
        .a_seg    (a_seg),
        .b_seg    (b_seg),
        .bsel     (borrow),
        .d_seg    (d_seg),
        .bout_seg (bout_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seg_idx     <= '0;
            borrow      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            diff_r      <= '0;
            out_valid_r <= 1'b0;
            bout_r      <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        borrow  <= bus.bin;
                        seg_idx <= '0;
                        diff_r  <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    diff_r  <= diff_nxt;
                    borrow  <= bout_seg;
                    seg_idx <= seg_idx + IDX_W'(1);
                    if (last_seg) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        bout_r      <= bout_seg;
                        zero_r      <= (diff_nxt == '0);
                        ovf_r       <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1],
                                               diff_nxt[WIDTH-1]);
                    end
                end
                DONE: begin
                    // Results are left in place after hand-off.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seg_borrow_select_sub.sv
module tb_seg_borrow_select_sub;
    import seg_borrow_select_sub_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg_borrow_select_sub_if #(.WIDTH(32)) bus ();

    seg_borrow_select_sub #(.WIDTH(32), .SEG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
    } vec_t;

    // Reference: plain wide arithmetic, unsigned compare for the borrow,
    // signed range check for overflow.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic bin, output logic [34:0] res);
        logic [31:0] d;
        logic        bo, z, ov;
        longint      sr;
        d  = a - b - 32'(bin);
        bo = ({1'b0, a} < ({1'b0, b} + 33'(bin)));
        z  = (d == 32'd0);
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        res = {d, bo, z, ov};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic bin, output int lat, output bit tmo);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.bin      = 1'($urandom);
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.zero, bus.ovf}
            !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b ir=%b d=%h bo=%b z=%b ovf=%b, need ov=0 ir=1 d=0 bo=0 z=0 ovf=0",
                     bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.zero, bus.ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t       vecs[7];
        logic [34:0] exp;
        int         lat;
        bit         tmo;
        vecs = '{
            '{32'h0000_0005, 32'h0000_0003, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b0},
            '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0},
            '{32'h1234_5678, 32'h1234_5677, 1'b1},
            '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1}
        };
        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].b, vecs[i].bin, exp);
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, tmo);
            n_tests++;
            if (tmo || lat != NSEG_DEF) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (timeout=%0b), need %0d",
                         i, lat, tmo, NSEG_DEF);
            end
            n_tests++;
            if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== exp) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got d=%h bo=%b z=%b ovf=%b, need d=%h bo=%b z=%b ovf=%b",
                         i, bus.diff, bus.bout, bus.zero, bus.ovf,
                         exp[34:3], exp[2], exp[1], exp[0]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        bin;
        logic [34:0] exp;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            bin = 1'($urandom);
            if (i % 5 == 0) b = a - 32'($urandom_range(0, 2));
            model(a, b, bin, exp);
            run_op(a, b, bin, lat, tmo);
            n_tests++;
            if (tmo || {bus.diff, bus.bout, bus.zero, bus.ovf} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h bin=%b: got d=%h bo=%b z=%b ovf=%b (timeout=%0b), need d=%h bo=%b z=%b ovf=%b",
                         i, a, b, bin, bus.diff, bus.bout, bus.zero, bus.ovf, tmo,
                         exp[34:3], exp[2], exp[1], exp[0]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] exp, exp2;
        int          lat;
        bit          tmo;
        model(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, exp);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, lat, tmo);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.bin      = 1'($urandom);
            @(posedge clk);
            #1;
            n_tests++;
            if (tmo || {bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.zero, bus.ovf}
                       !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b res=%h, need ov=1 ir=0 res=%h",
                         c, bus.out_valid, bus.in_ready,
                         {bus.diff, bus.bout, bus.zero, bus.ovf}, exp);
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.diff} !== {1'b1, 1'b0, exp[34:3]}) begin
            n_fail++;
            $display("FAIL backpressure_release: got ir=%b ov=%b d=%h, need ir=1 ov=0 d=%h",
                     bus.in_ready, bus.out_valid, bus.diff, exp[34:3]);
        end
        model(32'h0000_1000, 32'h0000_0FFF, 1'b0, exp2);
        run_op(32'h0000_1000, 32'h0000_0FFF, 1'b0, lat, tmo);
        n_tests++;
        if (tmo || {bus.diff, bus.bout, bus.zero, bus.ovf} !== exp2) begin
            n_fail++;
            $display("FAIL backpressure_next_op: got res=%h (timeout=%0b), need %h",
                     {bus.diff, bus.bout, bus.zero, bus.ovf}, tmo, exp2);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [34:0] exp;
        int          lat;
        bit          tmo;
        bit          pulsed;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_0000;
        bus.b        = 32'h0000_0001;
        bus.bin      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_running: got in_ready=%b, need 0", bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.in_ready, bus.diff} !== {1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got ov=%b ir=%b d=%h, need ov=0 ir=1 d=0",
                     bus.out_valid, bus.in_ready, bus.diff);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulsed = 1'b1;
        end
        n_tests++;
        if (pulsed || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_no_pulse: got pulse=%b ir=%b, need pulse=0 ir=1",
                     pulsed, bus.in_ready);
        end
        model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, exp);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, tmo);
        n_tests++;
        if (tmo || {bus.diff, bus.bout, bus.zero, bus.ovf} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_after: got d=%h bo=%b z=%b ovf=%b (timeout=%0b), need d=%h bo=%b z=%b ovf=%b",
                     bus.diff, bus.bout, bus.zero, bus.ovf, tmo,
                     exp[34:3], exp[2], exp[1], exp[0]);
        end
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
